// File: rtl/nrzi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nrzi_pkg : shared constants and FSM encoding for the NRZI decoder     |
// | Revision : 1.0                                                        |
// +----------------------------------------------------------------------+
package nrzi_pkg;

  localparam int   STUFF_LEN_DEFAULT = 6;
  localparam logic IDLE_LEVEL        = 1'b1;

  typedef enum logic [0:0] {
    ST_DATA  = 1'b0,
    ST_STUFF = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/nrzi_bit_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nrzi_bit_decode : line-level tracker, emits one decoded bit per valid |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module nrzi_bit_decode
  import nrzi_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_line,
  input  logic sync_clr,
  output logic dec_bit,
  output logic bit_valid
);

  logic r_prev_level;

  // No transition on the line means a 1.
  assign dec_bit   = (in_line == r_prev_level);
  assign bit_valid = in_valid & ~sync_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_level <= IDLE_LEVEL;
    end else if (sync_clr) begin
      r_prev_level <= IDLE_LEVEL;
    end else if (in_valid) begin
      r_prev_level <= in_line;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nrzi_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nrzi_decoder : NRZI decode, bit-unstuffing and byte assembly          |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
module nrzi_decoder
  import nrzi_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_line,
  input  logic       sync_clr,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       stuff_err,
  output logic       overrun
);

  localparam int CNT_W = $clog2(STUFF_LEN + 1);

  logic             w_dec_bit;
  logic             w_bit_valid;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_ones_cnt, w_ones_nxt, w_ones_inc;
  logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]       r_byte, w_byte_nxt;
  logic             w_complete;
  logic             w_stuff_viol;

  nrzi_bit_decode u_bit_decode (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_line   (in_line),
    .sync_clr  (sync_clr),
    .dec_bit   (w_dec_bit),
    .bit_valid (w_bit_valid)
  );

  assign w_ones_inc = r_ones_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_DATA;
      r_ones_cnt <= '0;
      r_bit_cnt  <= '0;
      r_byte     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ones_cnt <= w_ones_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_byte     <= w_byte_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ones_nxt    = r_ones_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_byte_nxt    = r_byte;
    w_complete    = 1'b0;
    w_stuff_viol  = 1'b0;
    if (sync_clr) begin
      w_state_nxt   = ST_DATA;
      w_ones_nxt    = '0;
      w_bit_cnt_nxt = '0;
    end else if (w_bit_valid) begin
      case (r_state)
        ST_DATA: begin
          w_byte_nxt[r_bit_cnt] = w_dec_bit;
          w_bit_cnt_nxt         = r_bit_cnt + 3'd1;
          w_complete            = (r_bit_cnt == 3'd7);
          if (w_dec_bit) begin
            w_ones_nxt = w_ones_inc;
            // The run-completing 1 is still data; only the next bit is stuffing.
            if (w_ones_inc == CNT_W'(STUFF_LEN)) begin
              w_state_nxt = ST_STUFF;
            end
          end else begin
            w_ones_nxt = '0;
          end
        end
        ST_STUFF: begin
          w_ones_nxt  = '0;
          w_state_nxt = ST_DATA;
          if (w_dec_bit) begin
            w_stuff_viol  = 1'b1;
            w_bit_cnt_nxt = '0;
            w_byte_nxt    = '0;
          end
        end
        default: w_state_nxt = ST_DATA;
      endcase
    end
  end

  // Single-entry output register; a byte finishing while it is full is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      stuff_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      stuff_err <= w_stuff_viol;
      overrun   <= 1'b0;
      if (w_complete) begin
        if (!out_valid || out_ready) begin
          out_data  <= w_byte_nxt;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nrzi_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nrzi_decoder : directed vectors against a bit/byte-level model     |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module tb_nrzi_decoder;
  import nrzi_pkg::*;

  localparam int STUFF_LEN = STUFF_LEN_DEFAULT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_line = 1'b1;
  logic       sync_clr = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       stuff_err;
  logic       overrun;

  nrzi_decoder #(.STUFF_LEN(STUFF_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_line   (in_line),
    .sync_clr  (sync_clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .stuff_err (stuff_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Model: decoded bits are collected into a list; a full list of 8 is a byte.
  logic       m_prev;
  int         m_run;
  bit         m_expect_stuff;
  logic [7:0] m_bits;
  int         m_n;
  logic [7:0] m_out;
  logic       m_valid;
  logic       m_serr;
  logic       m_ovr;
  logic       m_b;
  bit         m_done;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = 1'b1; m_run = 0; m_expect_stuff = 0; m_bits = '0; m_n = 0;
      m_out = 8'h00; m_valid = 1'b0; m_serr = 1'b0; m_ovr = 1'b0;
    end else begin
      m_serr = 1'b0;
      m_ovr  = 1'b0;
      m_done = 0;
      if (sync_clr) begin
        m_prev = 1'b1; m_run = 0; m_expect_stuff = 0; m_n = 0;
      end else if (in_valid) begin
        m_b    = (in_line == m_prev);
        m_prev = in_line;
        if (m_expect_stuff) begin
          m_expect_stuff = 0;
          m_run = 0;
          if (m_b) begin
            m_serr = 1'b1;
            m_n = 0;
          end
        end else begin
          m_bits[m_n] = m_b;
          m_n++;
          m_run = m_b ? m_run + 1 : 0;
          if (m_run == STUFF_LEN) m_expect_stuff = 1;
          if (m_n == 8) begin
            m_done = 1;
            m_n = 0;
          end
        end
      end
      if (m_done) begin
        if (!m_valid || out_ready) begin
          m_out = m_bits;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  int         n_checks = 0;
  int         n_errors = 0;
  int         valid_cycles = 0;
  int         serr_pulses = 0;
  int         ovr_pulses = 0;
  logic [7:0] last_data = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_bit(input logic v);
    @(negedge clk);
    sync_clr = 1'b0;
    in_valid = 1'b1;
    in_line  = v;
  endtask

  // Characters of s are line levels, leftmost sent first.
  task automatic send(input string s);
    for (int i = 0; i < s.len(); i++) drive_bit(s[i] == "1");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      sync_clr = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    sync_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam string A5_LINE = "10010011";

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, s0, o0;
    fork
      forever begin
        @(negedge clk);
        chk("out_valid", int'(out_valid), int'(m_valid));
        chk("out_data", int'(out_data), int'(m_out));
        chk("stuff_err", int'(stuff_err), int'(m_serr));
        chk("overrun", int'(overrun), int'(m_ovr));
        if (out_valid) begin
          valid_cycles++;
          last_data = out_data;
        end
        if (stuff_err) serr_pulses++;
        if (overrun) ovr_pulses++;
      end
      begin
        // Reset state
        #1;
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_data", int'(out_data), 8'h00);
        do_reset();

        // Single 0xA5, consumer always ready
        out_ready = 1'b1;
        v0 = valid_cycles;
        send(A5_LINE); idle(3);
        chk("a5_byte", int'(last_data), 8'hA5);
        chk("a5_valid_cycles", valid_cycles - v0, 1);

        // Six 1s followed by a stuffed 0
        do_reset();
        v0 = valid_cycles; s0 = serr_pulses;
        send("111111000"); idle(3);
        chk("ff_byte", int'(last_data), 8'hFF);
        chk("ff_no_stuff_err", serr_pulses - s0, 0);
        chk("ff_valid_cycles", valid_cycles - v0, 1);

        // Seven 1s: stuffing violation, then recovery
        do_reset();
        v0 = valid_cycles; s0 = serr_pulses;
        send("1111111"); idle(3);
        chk("viol_stuff_err", serr_pulses - s0, 1);
        chk("viol_no_valid", valid_cycles - v0, 0);
        send(A5_LINE); idle(3);
        chk("viol_recover_byte", int'(last_data), 8'hA5);

        // Back-to-back bytes while stalled
        do_reset();
        out_ready = 1'b0;
        o0 = ovr_pulses;
        send({A5_LINE, A5_LINE}); idle(2);
        chk("stall_overrun", ovr_pulses - o0, 1);
        chk("stall_valid", int'(out_valid), 1);
        chk("stall_data", int'(out_data), 8'hA5);
        idle(5);
        chk("stall_hold_data", int'(out_data), 8'hA5);
        @(negedge clk); out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        chk("stall_drained", int'(out_valid), 0);

        // Accept in the same cycle the second byte (0x5A) completes
        do_reset();
        out_ready = 1'b0;
        o0 = ovr_pulses;
        send(A5_LINE);
        send("0011100");
        @(negedge clk); in_valid = 1'b1; in_line = 1'b1; out_ready = 1'b1;
        @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
        chk("same_cycle_valid", int'(out_valid), 1);
        chk("same_cycle_data", int'(out_data), 8'h5A);
        idle(2);
        chk("same_cycle_no_overrun", ovr_pulses - o0, 0);
        out_ready = 1'b1; idle(2);

        // sync_clr mid-byte, with in_valid asserted alongside it
        do_reset();
        out_ready = 1'b1;
        v0 = valid_cycles;
        send("1001");
        @(negedge clk); sync_clr = 1'b1; in_valid = 1'b1; in_line = 1'b0;
        send(A5_LINE); idle(3);
        chk("sync_byte", int'(last_data), 8'hA5);
        chk("sync_valid_cycles", valid_cycles - v0, 1);

        // Asynchronous reset with a pending byte and a partial byte
        do_reset();
        out_ready = 1'b0;
        send(A5_LINE);
        send("100");
        @(negedge clk); in_valid = 1'b0;
        chk("pre_rst_valid", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_data", int'(out_data), 8'h00);
        chk("async_rst_flags", int'({stuff_err, overrun}), 0);
        @(negedge clk); rst_n = 1'b1;
        out_ready = 1'b1;
        send(A5_LINE); idle(3);
        chk("post_rst_byte", int'(last_data), 8'hA5);
      end
    join_any
    disable fork;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nrzi_decoder.md
NRZI_DECODER -- requirements
Module: nrzi_decoder

Interface
REQ-001 Parameter STUFF_LEN, default 6: number of consecutive decoded 1s after which one stuffed bit is expected.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  in_line carries one line bit this cycle.
REQ-005 in_line  input  1  NRZI-encoded serial line level.
REQ-006 sync_clr  input  1  resynchronise byte/stuff tracking; does not touch the output register.
REQ-007 out_data  output  8  decoded byte, LSB received first.
REQ-008 out_valid  output  1  out_data holds an unconsumed byte.
REQ-009 out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
REQ-010 stuff_err  output  1  one-cycle pulse: stuffing rule violated.
REQ-011 overrun  output  1  one-cycle pulse: completed byte dropped because the output register was full.

Function
REQ-012 Decode, per in_valid cycle: bit = 1 when in_line == prev_level, 0 when they differ; prev_level <= in_line; cycles with in_valid=0 change nothing.
REQ-013 FSM states: ST_DATA, ST_STUFF; reset/sync_clr state is ST_DATA.
REQ-014 ST_DATA: decoded 1 increments ones_cnt; decoded 0 clears it; each bit is shifted into the byte at position bit_cnt.
REQ-015 ST_DATA: when a decoded 1 brings ones_cnt to STUFF_LEN, next state is ST_STUFF (that 1 is still a data bit).
REQ-016 ST_STUFF, decoded 0: bit discarded, ones_cnt <= 0, next state ST_DATA.
REQ-017 ST_STUFF, decoded 1: stuff_err pulses next cycle, bit discarded, ones_cnt <= 0, bit_cnt <= 0, partial byte discarded, next state ST_DATA.
REQ-018 bit_cnt 3 bits, wraps 7->0; byte completes on the data bit written at bit_cnt=7.
REQ-019 Byte completion, output register empty or being accepted this cycle: out_data <= byte, out_valid = 1 the following cycle (latency: 1 cycle after last in_valid bit).
REQ-020 Byte completion while out_valid=1 and out_ready=0: byte dropped, out_data/out_valid unchanged, overrun pulses next cycle.
REQ-021 Accept with no completion in the same cycle: out_valid <= 0; out_data keeps its value.
REQ-022 out_valid, once set, stays high with out_data stable until accepted.
REQ-023 sync_clr=1: prev_level <= 1, ones_cnt <= 0, bit_cnt <= 0, state ST_DATA; in_valid that cycle is ignored; sync_clr has priority over in_valid.
REQ-024 ones_cnt width = clog2(STUFF_LEN+1); it never exceeds STUFF_LEN.

Reset
REQ-025 rst_n low, immediately and independent of clk: prev_level=1, ones_cnt=0, bit_cnt=0, state ST_DATA, out_data=8'h00, out_valid=0, stuff_err=0, overrun=0.
REQ-026 Reset mid-byte discards partial byte and any pending output; the first in_valid bit after release decodes against prev_level=1.

Structure
REQ-027 Package nrzi_pkg holds STUFF_LEN default, the FSM state encodings, and IDLE_LEVEL=1.
REQ-028 Sub-module nrzi_bit_decode holds the prev_level register and the comparison and produces bit plus bit_valid; nrzi_decoder instantiates it once.

Verification
REQ-029 After reset, line 1,0,0,1,0,0,1,1 with in_valid continuous, out_ready=1 -> out_data=8'hA5, out_valid high exactly one cycle.
REQ-030 Line 1,1,1,1,1,1,0,0,0 (six 1s, stuffed 0, two 1s) -> out_data=8'hFF, stuff_err never asserted.
REQ-031 Line seven consecutive 1s after reset -> stuff_err single pulse, no out_valid; the following 0xA5 sequence (starting from prev_level=1) decodes correctly.
REQ-032 Two back-to-back 0xA5 bytes, out_ready=0 -> first byte held, overrun pulses once, out_data stays 8'hA5 until out_ready=1.
REQ-033 out_ready=1 asserted in the same cycle the second byte completes -> no overrun, out_valid stays high, second byte presented.
REQ-034 sync_clr after 4 bits of a byte, then full 0xA5 line sequence -> out_data=8'hA5; rst_n pulsed mid-byte -> all outputs 0 asynchronously.
